// File: rtl/pong_link_pkg.sv
// rtl/pong_link_pkg.sv - shared command, register map and packet constants for the pong board link
package pong_link_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_STOP  = 2'd2
    } cmd_op_t;

    localparam logic [7:0] REG_BALL_BASE      = 8'h00;
    localparam logic [7:0] REG_WIN            = 8'h05;
    localparam logic [2:0] BALL_PKT_LEN       = 3'd5;
    localparam logic [2:0] WIN_PKT_LEN        = 3'd1;
    localparam int         PKT_BUF_LEN        = 6;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h42;

    // Address byte of a write transfer: 7-bit address with R/W = 0.
    function automatic logic [7:0] addr_write_byte(input logic [6:0] addr);
        return {addr, 1'b0};
    endfunction

endpackage

// File: rtl/link_cmd_port.sv
// rtl/link_cmd_port.sv - single-outstanding command handshake with response timeout
module link_cmd_port
    import pong_link_pkg::*;
#(
    parameter int RESP_TIMEOUT = 25000
) (
    input  logic       clk_25MHZ,
    input  logic       reset,
    input  logic       req,
    input  cmd_op_t    op,
    input  logic [7:0] data,
    output logic       cmd_valid,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_data,
    input  logic       cmd_ready,
    input  logic       resp_valid,
    input  logic       resp_nack,
    output logic       rsp_ok,
    output logic       rsp_nack,
    output logic       rsp_timeout
);

    localparam logic [14:0] TIMEOUT_LAST = 15'(RESP_TIMEOUT - 1);

    logic        waiting;
    logic [14:0] timeout_cnt;
    logic        is_write;
    logic        timeout_hit;

    assign is_write    = (op == CMD_WRITE);
    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);

    // The command is offered while requested and nothing is outstanding;
    // op/data are zeroed outside a valid WRITE so the bus stays quiet.
    assign cmd_valid = req & ~waiting;
    assign cmd_op    = cmd_valid ? op : CMD_START;
    assign cmd_data  = (cmd_valid && is_write) ? data : 8'h00;

    // NACK only means something on a WRITE; a response that lands on the
    // last counted cycle still wins over the timeout.
    assign rsp_ok      = waiting & resp_valid & ~(resp_nack & is_write);
    assign rsp_nack    = waiting & resp_valid & resp_nack & is_write;
    assign rsp_timeout = waiting & ~resp_valid & timeout_hit;

    // Track the outstanding command and count cycles since it was accepted.
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            waiting     <= 1'b0;
            timeout_cnt <= '0;
        end else if (cmd_valid && cmd_ready) begin
            waiting     <= 1'b1;
            timeout_cnt <= '0;
        end else if (waiting) begin
            if (resp_valid || timeout_hit) begin
                waiting     <= 1'b0;
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + 15'd1;
            end
        end
    end

endmodule

// File: rtl/ball_link_tx_sequencer.sv
// rtl/ball_link_tx_sequencer.sv - ball/win packet sequencer driving the byte-level I2C master
module ball_link_tx_sequencer
    import pong_link_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR     = DEFAULT_SLAVE_ADDR,
    parameter int         MAX_RETRY      = 3,
    parameter int         RESP_TIMEOUT   = 25000,
    parameter int         BACKOFF_CYCLES = 2500
) (
    input  logic       clk_25MHZ,
    input  logic       reset,
    input  logic       ball_req,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_vy,
    input  logic [1:0] gravity_phase,
    input  logic       ball_fast,
    input  logic       win_req,
    input  logic       win_flag,
    output logic       cmd_valid,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_data,
    input  logic       cmd_ready,
    input  logic       resp_valid,
    input  logic       resp_nack,
    output logic       busy,
    output logic       done,
    output logic       done_win,
    output logic       fail
);

    localparam int                 RETRY_W      = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
    localparam logic [11:0]        BACKOFF_LAST = 12'(BACKOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_REG,
        S_DATA,
        S_STOP,
        S_BACKOFF,
        S_FINISH
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [7:0]         pkt [PKT_BUF_LEN];
    logic [2:0]         pkt_len;
    logic [7:0]         reg_addr;
    logic               is_win;
    logic [2:0]         idx;
    logic [RETRY_W-1:0] retry;
    logic               failed;
    logic [11:0]        backoff_cnt;

    logic               port_req;
    cmd_op_t            port_op;
    logic [7:0]         port_data;
    logic               rsp_ok;
    logic               rsp_nack;
    logic               rsp_timeout;
    logic               rsp_fail;
    logic               accept_req;
    logic               backoff_done;
    logic               can_retry;
    logic               last_byte;

    assign rsp_fail     = rsp_nack | rsp_timeout;
    assign accept_req   = (state == S_IDLE) && (win_req || ball_req);
    assign backoff_done = (state == S_BACKOFF) && (backoff_cnt == BACKOFF_LAST);
    assign can_retry    = (retry < RETRY_LIMIT);
    assign last_byte    = (idx == pkt_len - 3'd1);

    link_cmd_port #(
        .RESP_TIMEOUT (RESP_TIMEOUT)
    ) u_cmd_port (
        .clk_25MHZ   (clk_25MHZ),
        .reset       (reset),
        .req         (port_req),
        .op          (port_op),
        .data        (port_data),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .resp_valid  (resp_valid),
        .resp_nack   (resp_nack),
        .rsp_ok      (rsp_ok),
        .rsp_nack    (rsp_nack),
        .rsp_timeout (rsp_timeout)
    );

    // State register.
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Snapshot the winning request's payload so later input changes are not sent.
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PKT_BUF_LEN; i++) begin
                pkt[i] <= 8'h00;
            end
            pkt_len  <= 3'd0;
            reg_addr <= 8'h00;
            is_win   <= 1'b0;
        end else if (accept_req) begin
            if (win_req) begin
                pkt[0]   <= {7'b0, win_flag};
                pkt[1]   <= 8'h00;
                pkt[2]   <= 8'h00;
                pkt[3]   <= 8'h00;
                pkt[4]   <= 8'h00;
                pkt[5]   <= 8'h00;
                pkt_len  <= WIN_PKT_LEN;
                reg_addr <= REG_WIN;
                is_win   <= 1'b1;
            end else begin
                pkt[0]   <= {ball_y[9:8], 6'b0};
                pkt[1]   <= ball_y[7:0];
                pkt[2]   <= ball_vy;
                pkt[3]   <= {6'b0, gravity_phase};
                pkt[4]   <= {7'b0, ball_fast};
                pkt[5]   <= 8'h00;
                pkt_len  <= BALL_PKT_LEN;
                reg_addr <= REG_BALL_BASE;
                is_win   <= 1'b0;
            end
        end
    end

    // Byte index, retry count, failure mark and backoff timer.
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            idx         <= 3'd0;
            retry       <= '0;
            failed      <= 1'b0;
            backoff_cnt <= 12'd0;
        end else begin
            if (accept_req) begin
                idx    <= 3'd0;
                retry  <= '0;
                failed <= 1'b0;
            end
            if (state == S_DATA && rsp_ok) begin
                idx <= idx + 3'd1;
            end
            if ((state inside {S_ADDR, S_REG, S_DATA}) && rsp_fail) begin
                failed <= 1'b1;
            end
            if (state == S_BACKOFF) begin
                if (backoff_done) begin
                    backoff_cnt <= 12'd0;
                    if (can_retry) begin
                        retry  <= retry + 1'b1;
                        idx    <= 3'd0;
                        failed <= 1'b0;
                    end
                end else begin
                    backoff_cnt <= backoff_cnt + 12'd1;
                end
            end
        end
    end

    // Next state, command selection and status outputs.
    always_comb begin
        state_n   = state;
        port_req  = 1'b0;
        port_op   = CMD_START;
        port_data = 8'h00;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        done_win  = 1'b0;
        fail      = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_req || ball_req) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                port_req = 1'b1;
                port_op  = CMD_START;
                // A START that never completes has no bus to release.
                if (rsp_ok || rsp_nack) begin
                    state_n = S_ADDR;
                end else if (rsp_timeout) begin
                    state_n = S_BACKOFF;
                end
            end
            S_ADDR: begin
                port_req  = 1'b1;
                port_op   = CMD_WRITE;
                port_data = addr_write_byte(SLAVE_ADDR);
                if (rsp_ok) begin
                    state_n = S_REG;
                end else if (rsp_fail) begin
                    state_n = S_STOP;
                end
            end
            S_REG: begin
                port_req  = 1'b1;
                port_op   = CMD_WRITE;
                port_data = reg_addr;
                if (rsp_ok) begin
                    state_n = S_DATA;
                end else if (rsp_fail) begin
                    state_n = S_STOP;
                end
            end
            S_DATA: begin
                port_req  = 1'b1;
                port_op   = CMD_WRITE;
                port_data = pkt[idx];
                if (rsp_ok) begin
                    state_n = last_byte ? S_STOP : S_DATA;
                end else if (rsp_fail) begin
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                port_req = 1'b1;
                port_op  = CMD_STOP;
                if (rsp_ok || rsp_nack) begin
                    state_n = failed ? S_BACKOFF : S_FINISH;
                end else if (rsp_timeout) begin
                    state_n = S_BACKOFF;
                end
            end
            S_BACKOFF: begin
                if (backoff_done) begin
                    if (can_retry) begin
                        state_n = S_START;
                    end else begin
                        fail    = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            S_FINISH: begin
                done     = 1'b1;
                done_win = is_win;
                state_n  = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ball_link_tx_sequencer.sv
// tb/tb_ball_link_tx_sequencer.sv - self-checking bench for ball_link_tx_sequencer
module tb_ball_link_tx_sequencer;
    import pong_link_pkg::*;

    localparam int TO = 300;
    localparam int BO = 40;
    localparam int MR = 3;

    logic       clk_25MHZ = 1'b0;
    logic       reset = 1'b1;
    logic       ball_req = 1'b0;
    logic [9:0] ball_y = '0;
    logic [7:0] ball_vy = '0;
    logic [1:0] gravity_phase = '0;
    logic       ball_fast = 1'b0;
    logic       win_req = 1'b0;
    logic       win_flag = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_ready = 1'b0;
    logic       resp_valid = 1'b0;
    logic       resp_nack = 1'b0;
    logic       busy;
    logic       done;
    logic       done_win;
    logic       fail;

    always #20 clk_25MHZ = ~clk_25MHZ;

    ball_link_tx_sequencer #(
        .SLAVE_ADDR     (7'h42),
        .MAX_RETRY      (MR),
        .RESP_TIMEOUT   (TO),
        .BACKOFF_CYCLES (BO)
    ) dut (
        .clk_25MHZ     (clk_25MHZ),
        .reset         (reset),
        .ball_req      (ball_req),
        .ball_y        (ball_y),
        .ball_vy       (ball_vy),
        .gravity_phase (gravity_phase),
        .ball_fast     (ball_fast),
        .win_req       (win_req),
        .win_flag      (win_flag),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .resp_valid    (resp_valid),
        .resp_nack     (resp_nack),
        .busy          (busy),
        .done          (done),
        .done_win      (done_win),
        .fail          (fail)
    );

    int cyc = 0;
    always @(posedge clk_25MHZ) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Master model configuration and observation log.
    int         ready_pct = 100;
    int         resp_delay = 1;
    bit         rand_delay = 0;
    bit         m_silent = 0;
    bit         m_stray = 0;
    bit         m_pending = 0;
    bit         m_nack_flag = 0;
    int         m_wait = 0;
    int         nack_at = -1;
    int         write_idx = 0;
    logic [9:0] log_q[$];
    int         log_cyc[$];
    int         done_cnt = 0;
    int         fail_cnt = 0;
    int         fail_cyc = 0;
    logic       last_done_win = 1'b0;

    initial begin
        forever begin
            @(negedge clk_25MHZ);
            resp_valid = 1'b0;
            resp_nack  = 1'b0;
            if (reset) m_pending = 0;
            if (m_stray) begin
                resp_valid = 1'b1;
                m_stray = 0;
            end
            if (m_pending) begin
                m_wait--;
                if (m_wait <= 0) begin
                    m_pending  = 0;
                    resp_valid = 1'b1;
                    resp_nack  = m_nack_flag;
                end
            end
            cmd_ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (done) begin
                done_cnt++;
                last_done_win = done_win;
            end
            if (fail) begin
                fail_cnt++;
                fail_cyc = cyc;
            end
            if (cmd_valid && cmd_ready && !reset) begin
                log_q.push_back({cmd_op, cmd_data});
                log_cyc.push_back(cyc);
                m_nack_flag = (cmd_op == 2'd1) && (write_idx == nack_at);
                if (cmd_op == 2'd1) write_idx++;
                if (!m_silent) begin
                    m_pending = 1;
                    m_wait = rand_delay ? $urandom_range(1, 4) : resp_delay;
                end
            end
        end
    end

    // Reference model: the command stream a packet must produce.
    logic [9:0] exp_q[$];

    task automatic model_txn(input bit w, input bit flag, input logic [9:0] y,
                             input logic [7:0] vy, input logic [1:0] g, input bit f);
        logic [7:0] body[$];
        if (w) body = '{8'h05, {7'b0, flag}};
        else   body = '{8'h00, {y[9:8], 6'b0}, y[7:0], vy, {6'b0, g}, {7'b0, f}};
        exp_q.push_back({2'd0, 8'h00});
        exp_q.push_back({2'd1, 8'h84});
        foreach (body[i]) exp_q.push_back({2'd1, body[i]});
        exp_q.push_back({2'd2, 8'h00});
    endtask

    task automatic compare_log(input string name);
        int n;
        check($sformatf("%s_len", name), log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", name, i), log_q[i], exp_q[i]);
        end
    endtask

    task automatic wait_end(input string name, input int max);
        int  d0 = done_cnt;
        int  f0 = fail_cnt;
        bit  ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_25MHZ);
            #2;
            if (done_cnt != d0 || fail_cnt != f0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check($sformatf("%s_end_timeout", name), 0, 1);
    endtask

    task automatic wait_log(input string name, input int n, input int max);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_25MHZ);
            #2;
            if (log_q.size() >= n) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check($sformatf("%s_log_timeout", name), 0, 1);
    endtask

    task automatic set_ball(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g, input bit f);
        ball_y = y;
        ball_vy = vy;
        gravity_phase = g;
        ball_fast = f;
    endtask

    typedef struct {
        bit         w;
        bit         flag;
        logic [9:0] y;
        logic [7:0] vy;
        logic [1:0] g;
        bit         f;
        int         nb;
        logic [55:0] bytes;
        bit         exp_win;
    } vec_t;

    vec_t vt[6];

    initial begin
        #2400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         d0;
        int         f0;
        int         stops;
        logic [9:0] tmp[$];
        logic [55:0] b;

        vt[0] = '{1'b0, 1'b0, 10'h2A5, 8'hFD, 2'd2, 1'b1, 7, 56'h84_00_80_A5_FD_02_01, 1'b0};
        vt[1] = '{1'b1, 1'b1, 10'h000, 8'h00, 2'd0, 1'b0, 3, 56'h84_05_01_00_00_00_00, 1'b1};
        vt[2] = '{1'b1, 1'b0, 10'h000, 8'h00, 2'd0, 1'b0, 3, 56'h84_05_00_00_00_00_00, 1'b1};
        vt[3] = '{1'b0, 1'b0, 10'h000, 8'h00, 2'd0, 1'b0, 7, 56'h84_00_00_00_00_00_00, 1'b0};
        vt[4] = '{1'b0, 1'b0, 10'h3FF, 8'h7F, 2'd3, 1'b0, 7, 56'h84_00_C0_FF_7F_03_00, 1'b0};
        vt[5] = '{1'b0, 1'b0, 10'h100, 8'h80, 2'd1, 1'b1, 7, 56'h84_00_40_00_80_01_01, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk_25MHZ);
        #2;
        check("rst_busy", busy, 0);
        check("rst_cmd", {cmd_valid, cmd_op, cmd_data}, 0);
        check("rst_status", {done, done_win, fail}, 0);
        reset = 1'b0;

        // Table of single transactions with an always-acking master.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_25MHZ);
            #2;
            log_q.delete();
            set_ball(vt[k].y, vt[k].vy, vt[k].g, vt[k].f);
            win_flag = vt[k].flag;
            win_req  = vt[k].w;
            ball_req = !vt[k].w;
            @(negedge clk_25MHZ);
            #2;
            check($sformatf("tbl%0d_latency", k), {busy, cmd_valid, cmd_op}, {1'b1, 1'b1, 2'd0});
            wait_end($sformatf("tbl%0d", k), 5000);
            win_req = 1'b0;
            ball_req = 1'b0;
            b = vt[k].bytes;
            check($sformatf("tbl%0d_len", k), log_q.size(), vt[k].nb + 2);
            if (log_q.size() == vt[k].nb + 2) begin
                check($sformatf("tbl%0d_start", k), log_q[0], {2'd0, 8'h00});
                for (int i = 0; i < vt[k].nb; i++) begin
                    check($sformatf("tbl%0d_w%0d", k, i), log_q[i + 1], {2'd1, b[55 - 8*i -: 8]});
                end
                check($sformatf("tbl%0d_stop", k), log_q[vt[k].nb + 1], {2'd2, 8'h00});
            end
            check($sformatf("tbl%0d_done_win", k), last_done_win, vt[k].exp_win);
        end

        // Simultaneous win and ball: win first, IDLE for one cycle, then ball.
        @(negedge clk_25MHZ);
        #2;
        log_q.delete();
        exp_q.delete();
        set_ball(10'h2A5, 8'hFD, 2'd2, 1'b1);
        win_flag = 1'b1;
        win_req  = 1'b1;
        ball_req = 1'b1;
        model_txn(1, 1, 0, 0, 0, 0);
        wait_end("tie_win", 5000);
        win_req = 1'b0;
        compare_log("tie_win");
        check("tie_win_done_win", last_done_win, 1);
        @(negedge clk_25MHZ);
        #2;
        check("tie_idle_gap", {busy, done}, 2'b00);
        log_q.delete();
        exp_q.delete();
        model_txn(0, 0, 10'h2A5, 8'hFD, 2'd2, 1'b1);
        wait_end("tie_ball", 5000);
        ball_req = 1'b0;
        compare_log("tie_ball");
        check("tie_ball_done_win", last_done_win, 0);

        // NACK on first data byte: STOP, backoff, full resend, single done.
        @(negedge clk_25MHZ);
        #2;
        log_q.delete();
        log_cyc.delete();
        exp_q.delete();
        write_idx = 0;
        nack_at = 2;
        d0 = done_cnt;
        f0 = fail_cnt;
        set_ball(10'h155, 8'h12, 2'd1, 1'b0);
        ball_req = 1'b1;
        exp_q.push_back({2'd0, 8'h00});
        exp_q.push_back({2'd1, 8'h84});
        exp_q.push_back({2'd1, 8'h00});
        exp_q.push_back({2'd1, 8'h40});
        exp_q.push_back({2'd2, 8'h00});
        model_txn(0, 0, 10'h155, 8'h12, 2'd1, 1'b0);
        wait_end("nack", 5000);
        ball_req = 1'b0;
        nack_at = -1;
        compare_log("nack");
        if (log_cyc.size() >= 6) check("nack_backoff_gap", log_cyc[5] - log_cyc[4], BO + 2);
        repeat (3) @(negedge clk_25MHZ);
        #2;
        check("nack_done_count", done_cnt - d0, 1);
        check("nack_no_fail", fail_cnt - f0, 0);

        // Response exactly on the last timeout cycle is accepted.
        log_q.delete();
        exp_q.delete();
        resp_delay = TO;
        d0 = done_cnt;
        f0 = fail_cnt;
        win_flag = 1'b0;
        win_req = 1'b1;
        model_txn(1, 0, 0, 0, 0, 0);
        wait_end("tmo_edge", 20000);
        win_req = 1'b0;
        compare_log("tmo_edge");
        check("tmo_edge_result", {done_cnt - d0, fail_cnt - f0}, {32'd1, 32'd0});

        // One cycle too late every time: four START attempts, then fail.
        @(negedge clk_25MHZ);
        #2;
        log_q.delete();
        log_cyc.delete();
        resp_delay = TO + 1;
        d0 = done_cnt;
        f0 = fail_cnt;
        ball_req = 1'b1;
        wait_end("exhaust", 20000);
        ball_req = 1'b0;
        resp_delay = 1;
        check("exhaust_attempts", log_q.size(), MR + 1);
        for (int i = 0; i < log_q.size(); i++) begin
            check($sformatf("exhaust_op%0d", i), log_q[i], {2'd0, 8'h00});
            if (i > 0) check($sformatf("exhaust_gap%0d", i), log_cyc[i] - log_cyc[i-1], TO + BO + 1);
        end
        if (log_cyc.size() > 0) check("exhaust_fail_time", fail_cyc - log_cyc[log_cyc.size() - 1], TO + BO);
        repeat (4) @(negedge clk_25MHZ);
        #2;
        check("exhaust_counts", {done_cnt - d0, fail_cnt - f0}, {32'd0, 32'd1});
        check("exhaust_busy", busy, 0);

        // Stray response while idle is ignored.
        log_q.delete();
        m_stray = 1;
        repeat (3) @(negedge clk_25MHZ);
        #2;
        check("stray_idle", {busy, cmd_valid, 30'(log_q.size())}, 0);

        // Snapshot: payload changes after acceptance are not transmitted.
        exp_q.delete();
        set_ball(10'h155, 8'h12, 2'd1, 1'b0);
        ball_req = 1'b1;
        model_txn(0, 0, 10'h155, 8'h12, 2'd1, 1'b0);
        wait_log("snap", 2, 100);
        set_ball(10'h2AA, 8'hEE, 2'd3, 1'b1);
        wait_end("snap", 5000);
        ball_req = 1'b0;
        compare_log("snap");

        // Reset during DATA: outputs clear at once, no STOP is issued.
        @(negedge clk_25MHZ);
        #2;
        log_q.delete();
        ball_req = 1'b1;
        wait_log("rst_mid", 4, 100);
        reset = 1'b1;
        #1;
        check("rst_mid_outputs", {busy, cmd_valid, cmd_op, cmd_data, done, done_win, fail}, 0);
        @(negedge clk_25MHZ);
        #2;
        check("rst_mid_idle", busy, 0);
        ball_req = 1'b0;
        reset = 1'b0;
        repeat (5) @(negedge clk_25MHZ);
        #2;
        stops = 0;
        foreach (log_q[i]) if (log_q[i][9:8] == 2'd2) stops++;
        check("rst_mid_no_stop", stops, 0);
        check("rst_mid_quiet", {busy, cmd_valid}, 0);

        // Random payloads, ready gaps, response delays and optional NACK.
        rand_delay = 1;
        for (int r = 0; r < 25; r++) begin
            bit         w;
            bit         flag;
            logic [9:0] y;
            logic [7:0] vy;
            logic [1:0] g;
            bit         f;
            int         nw;
            @(negedge clk_25MHZ);
            #2;
            w = $urandom_range(0, 1);
            flag = $urandom_range(0, 1);
            y = 10'($urandom);
            vy = 8'($urandom);
            g = 2'($urandom);
            f = $urandom_range(0, 1);
            nw = w ? 3 : 7;
            log_q.delete();
            exp_q.delete();
            write_idx = 0;
            nack_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nw - 1) : -1;
            ready_pct = $urandom_range(40, 100);
            model_txn(w, flag, y, vy, g, f);
            if (nack_at >= 0) begin
                tmp = exp_q;
                exp_q = tmp[0 : nack_at + 1];
                exp_q.push_back({2'd2, 8'h00});
                foreach (tmp[i]) exp_q.push_back(tmp[i]);
            end
            d0 = done_cnt;
            set_ball(y, vy, g, f);
            win_flag = flag;
            win_req = w;
            ball_req = !w;
            wait_end($sformatf("rnd%0d", r), 5000);
            win_req = 1'b0;
            ball_req = 1'b0;
            compare_log($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_done", r), {done_cnt - d0, 31'(last_done_win)}, {32'd1, 31'(w)});
        end
        nack_at = -1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
